// File: rtl/multi_adc_capture.sv
`timescale 1ns / 1ps
// multi_adc_capture: N-channel ADC capture with level/edge trigger, per-channel
// sample RAMs and a sop/eop framed valid/ready readout. Optional feature: `PRETRIG_EN.
module multi_adc_capture #(
  parameter int unsigned CH_NUM      = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned PRE_SAMPLES = 256,
  localparam int unsigned CW         = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic [CH_NUM*DATA_W-1:0] adc_data,
  input  logic                     arm,
  input  logic                     force_trig,
  input  logic [CW-1:0]            trig_ch,
  input  logic [DATA_W-1:0]        trig_level,
  input  logic                     trig_falling,
  input  logic                     rd_start,
  input  logic [CW-1:0]            rd_ch,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned RW = AW + 1;
`ifdef PRETRIG_EN
  localparam int unsigned PRE_LEN   = PRE_SAMPLES;
  localparam bit          PRE_WRITE = 1'b1;
`else
  // PRE_SAMPLES is accepted so existing parameter overrides still elaborate
  localparam int unsigned PRE_LEN   = 0 * PRE_SAMPLES;
  localparam bit          PRE_WRITE = 1'b0;
`endif
  localparam int unsigned POST_LEN = DEPTH - PRE_LEN;

  typedef enum logic [2:0] {
    IDLE,
`ifdef PRETRIG_EN
    FILL,
`endif
    WAIT_TRIG,
    POST,
    DONE,
    READ
  } state_t;

  state_t            state;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     start_addr;
  logic [AW-1:0]     cnt;
  logic [RW-1:0]     rd_cnt;
  logic [CW-1:0]     rd_sel;
  logic [DATA_W-1:0] prev;
  logic              prev_valid;
  logic              s1_valid;
  logic              s1_sop;
  logic              s1_eop;

  logic [DATA_W-1:0] trig_sample;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_q [CH_NUM];
  logic              rise;
  logic              fall;
  logic              trig;
  logic              wr_en;
  logic              out_adv;
  logic              s1_en;
  logic              rd_issue;
  logic [AW-1:0]     rd_addr;
  logic              rd_in_range;
  logic              sampling;

  always_comb begin
    trig_sample = '0;
    rd_word     = '0;
    for (int unsigned k = 0; k < CH_NUM; k++) begin
      if (trig_ch == CW'(k)) trig_sample = adc_data[k*DATA_W +: DATA_W];
      if (rd_sel == CW'(k))  rd_word     = rd_q[k];
    end
  end

  always_comb begin
    rise        = prev_valid && (prev < trig_level) && (trig_sample >= trig_level);
    fall        = prev_valid && (prev > trig_level) && (trig_sample <= trig_level);
    trig        = force_trig || (trig_falling ? fall : rise);
    sampling    = (state == WAIT_TRIG);
`ifdef PRETRIG_EN
    sampling    = sampling || (state == FILL);
`endif
    wr_en       = (state == POST) || (state == WAIT_TRIG && (PRE_WRITE || trig));
`ifdef PRETRIG_EN
    wr_en       = wr_en || (state == FILL);
`endif
    // Two-stage read pipe: RAM output register feeds the output register
    out_adv     = !out_valid || out_ready;
    s1_en       = !s1_valid || out_adv;
    rd_issue    = (state == READ) && s1_en && !rd_cnt[AW];
    rd_addr     = start_addr + rd_cnt[AW-1:0];
    rd_in_range = 32'(rd_ch) < CH_NUM;
  end

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ram
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] q;
    always_ff @(posedge Clk) begin
      if (wr_en)    mem[wr_ptr] <= adc_data[k*DATA_W +: DATA_W];
      if (rd_issue) q <= mem[rd_addr];
    end
    assign rd_q[k] = q;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      start_addr <= '0;
      cnt        <= '0;
      rd_cnt     <= '0;
      rd_sel     <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      s1_valid   <= 1'b0;
      s1_sop     <= 1'b0;
      s1_eop     <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_err     <= 1'b0;
    end else begin
      rd_err <= rd_start && (state != IDLE) && (state != DONE);
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (sampling) begin
        prev       <= trig_sample;
        prev_valid <= 1'b1;
      end

      case (state)
        IDLE, DONE: begin
          if (arm) begin
`ifdef PRETRIG_EN
            state <= (PRE_LEN != 0) ? FILL : WAIT_TRIG;
`else
            state <= WAIT_TRIG;
`endif
            busy       <= 1'b1;
            done       <= 1'b0;
            wr_ptr     <= '0;
            cnt        <= '0;
            prev_valid <= 1'b0;
          end else if (rd_start) begin
            if (state == DONE && rd_in_range) begin
              state  <= READ;
              rd_sel <= rd_ch;
              rd_cnt <= '0;
            end else begin
              rd_err <= 1'b1;
            end
          end
        end
`ifdef PRETRIG_EN
        FILL: begin
          cnt <= cnt + AW'(1);
          if (cnt == AW'(PRE_LEN - 1)) state <= WAIT_TRIG;
        end
`endif
        WAIT_TRIG: begin
          if (trig) begin
            start_addr <= wr_ptr - AW'(PRE_LEN);
            if (POST_LEN == 1) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= POST;
              cnt   <= AW'(1);
            end
          end
        end
        POST: begin
          cnt <= cnt + AW'(1);
          if (cnt == AW'(POST_LEN - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        READ: begin
          if (s1_en) begin
            s1_valid <= rd_issue;
            s1_sop   <= (rd_cnt == '0);
            s1_eop   <= (rd_cnt == RW'(DEPTH - 1));
            if (rd_issue) rd_cnt <= rd_cnt + RW'(1);
          end
          if (out_adv) begin
            out_valid <= s1_valid;
            out_sop   <= s1_valid && s1_sop;
            out_eop   <= s1_valid && s1_eop;
            if (s1_valid) out_data <= rd_word;
          end
          if (out_valid && out_ready && out_eop) begin
            state     <= DONE;
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_adc_capture.sv
`timescale 1ns / 1ps
// Directed bench for multi_adc_capture: CH_NUM=4, DEPTH=16, plus a CH_NUM=3
// instance used only for the out-of-range read request.
module tb_multi_adc_capture;

  localparam int DEPTH = 16;
`ifdef PRETRIG_EN
  localparam int PRE = 4;
`else
  localparam int PRE = 0;
`endif
  localparam int L = DEPTH - PRE;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] adc_data;
  logic        arm, force_trig, trig_falling, rd_start, out_ready;
  logic [1:0]  trig_ch, rd_ch;
  logic [7:0]  trig_level;
  logic        out_valid, out_sop, out_eop, busy, done, rd_err;
  logic [7:0]  out_data;
  logic        rd_start3;
  logic [1:0]  rd_ch3;
  logic        out_valid3, out_sop3, out_eop3, busy3, done3, rd_err3;
  logic [7:0]  out_data3;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  v;
  int          step;
  logic [7:0]  t;

  always #5 clk = ~clk;

  multi_adc_capture #(.CH_NUM(4), .DATA_W(8), .DEPTH(DEPTH), .PRE_SAMPLES(4)) u_dut (
    .Clk(clk), .Reset_n(reset_n), .adc_data(adc_data), .arm(arm),
    .force_trig(force_trig), .trig_ch(trig_ch), .trig_level(trig_level),
    .trig_falling(trig_falling), .rd_start(rd_start), .rd_ch(rd_ch),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop), .busy(busy), .done(done), .rd_err(rd_err)
  );

  multi_adc_capture #(.CH_NUM(3), .DATA_W(8), .DEPTH(DEPTH), .PRE_SAMPLES(4)) u_dut3 (
    .Clk(clk), .Reset_n(reset_n), .adc_data(adc_data[23:0]), .arm(arm),
    .force_trig(force_trig), .trig_ch(trig_ch), .trig_level(trig_level),
    .trig_falling(trig_falling), .rd_start(rd_start3), .rd_ch(rd_ch3),
    .out_ready(out_ready), .out_valid(out_valid3), .out_data(out_data3),
    .out_sop(out_sop3), .out_eop(out_eop3), .busy(busy3), .done(done3), .rd_err(rd_err3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ch0 = v, ch1 = v, ch2 = v + 100, ch3 = ~v
  task automatic apply();
    adc_data = {~v, v + 8'd100, v, v};
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    v = v + 8'(step);
    apply();
  endtask

  task automatic wait_v(input logic [7:0] target);
    int n = 0;
    while (v != target && n < 400) begin
      tick();
      n++;
    end
    check("wait_v", {24'd0, v}, {24'd0, target});
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("arm_busy", busy, 1);
    check("arm_done", done, 0);
  endtask

  // Trigger sample is presented now; done must rise right after the last post sample.
  task automatic post_window(input int arm_at);
    tick();
    force_trig = 1'b0;
    for (int i = 0; i < L - 2; i++) begin
      if (i == arm_at) arm = 1'b1;
      tick();
      arm = 1'b0;
    end
    check("done_early", done, 0);
    tick();
    check("done_on_time", done, 1);
    check("busy_cleared", busy, 0);
  endtask

  task automatic read_frame(input logic [1:0] ch, input logic [7:0] first,
                            input int dir, input bit bp);
    int         beats = 0;
    int         cyc   = 0;
    bit         held  = 1'b0;
    logic [7:0] hd, exp;
    logic       hs, he;
    bit         pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    out_ready = 1'b1;
    rd_ch     = ch;
    rd_start  = 1'b1;
    tick();
    rd_start = 1'b0;
    check("rd_accept_err", rd_err, 0);
    tick();
    check("lat_valid_c1", out_valid, 0);
    tick();
    check("lat_valid_c2", out_valid, 1);
    while (beats < DEPTH && cyc < 200) begin
      if (bp) out_ready = pat[cyc % 4];
      if (!bp) check("no_bubble", out_valid, 1);
      if (held) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", {24'd0, out_data}, {24'd0, hd});
        check("hold_sop", out_sop, hs);
        check("hold_eop", out_eop, he);
      end
      held = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          exp = 8'(int'(first) + dir * beats);
          check("beat_data", {24'd0, out_data}, {24'd0, exp});
          check("beat_sop", out_sop, beats == 0);
          check("beat_eop", out_eop, beats == DEPTH - 1);
          beats++;
        end else begin
          held = 1'b1;
          hd   = out_data;
          hs   = out_sop;
          he   = out_eop;
        end
      end
      tick();
      cyc++;
    end
    out_ready = 1'b1;
    check("beat_count", beats, DEPTH);
    check("end_valid", out_valid, 0);
    check("end_done", done, 1);
    check("end_busy", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not reach its summary");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b1; arm = 1'b0; force_trig = 1'b0; trig_falling = 1'b0;
    rd_start = 1'b0; out_ready = 1'b1; trig_ch = 2'd0; rd_ch = 2'd0;
    trig_level = 8'd0; rd_start3 = 1'b0; rd_ch3 = 2'd0;
    v = 8'd0; step = 0; apply();
    #3 reset_n = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_sop", out_sop, 0);
    check("rst_eop", out_eop, 0);
    check("rst_data", {24'd0, out_data}, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_err", rd_err, 0);
    reset_n = 1'b1;
    tick();

    // Rising trigger at 50 on ch1
    trig_ch = 2'd1; trig_level = 8'd50; trig_falling = 1'b0;
    v = 8'd0; step = 1; apply();
    do_arm();
    wait_v(8'd50);
    check("t1_no_early", done, 0);
    post_window(-1);
    t = 8'(50 - PRE);
    read_frame(2'd1, t, 1, 1'b0);
    read_frame(2'd3, ~t, -1, 1'b0);

    // Falling trigger at 100; the earlier rising crossing must not fire
    trig_level = 8'd100; trig_falling = 1'b1;
    v = 8'd90; step = 1; apply();
    do_arm();
    wait_v(8'd110);
    step = -1;
    wait_v(8'd100);
    check("t2_no_rise_trig", done, 0);
    check("t2_busy", busy, 1);
    post_window(-1);
    t = 8'(100 + PRE);
    read_frame(2'd1, t, -1, 1'b0);

    // Backpressure on the same capture
    read_frame(2'd1, t, -1, 1'b1);

    // Reset in the middle of a read
    out_ready = 1'b0; rd_ch = 2'd1; rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    tick(); tick();
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_sop", out_sop, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_sop", out_sop, 0);
    check("mid_rst_eop", out_eop, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    check("idle_rd_err", rd_err, 1);
    check("idle_rd_valid", out_valid, 0);
    tick();
    check("idle_rd_err_pulse", rd_err, 0);

    // Forced + level trigger together, busy read rejected, arm in POST ignored
    trig_ch = 2'd0; trig_level = 8'd10; trig_falling = 1'b0;
    v = 8'd0; step = 1; apply();
    do_arm();
    wait_v(8'd5);
    rd_ch = 2'd0; rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    check("busy_rd_err", rd_err, 1);
    check("busy_rd_valid", out_valid, 0);
    tick();
    check("busy_rd_err_pulse", rd_err, 0);
    wait_v(8'd10);
    force_trig = 1'b1;
    post_window(3);
    t = 8'(10 - PRE) + 8'd100;
    read_frame(2'd2, t, 1, 1'b0);
    check("dut3_done", done3, 1);
    rd_ch3 = 2'd3; rd_start3 = 1'b1;
    tick();
    rd_start3 = 1'b0;
    check("range_rd_err", rd_err3, 1);
    check("range_rd_valid", out_valid3, 0);
    tick();
    check("range_rd_valid2", out_valid3, 0);
    check("range_done_kept", done3, 1);

`ifdef PRETRIG_EN
    // Pre-trigger capture: force during FILL ignored, trigger at 50 on ch0
    trig_ch = 2'd0; trig_level = 8'd50; trig_falling = 1'b0;
    v = 8'd0; step = 1; apply();
    do_arm();
    wait_v(8'd2);
    force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
    wait_v(8'd50);
    check("fill_force_ignored", done, 0);
    post_window(-1);
    read_frame(2'd0, 8'd46, 1, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
